// File: rtl/flag_pkg.sv
// Shared constants, sideband type and tree-sizing helpers for the pipelined NZCV flag unit.
package flag_pkg;

    localparam int N_BIT = 3;
    localparam int Z_BIT = 2;
    localparam int C_BIT = 1;
    localparam int V_BIT = 0;

    localparam int DEF_WIDTH      = 64;
    localparam int DEF_FANIN      = 4;
    localparam int DEF_REG_LEVELS = 1;

    typedef struct packed {
        logic n;
        logic c;
        logic v;
        logic set;
    } side_t;

    // Width of the vector entering reduction level lvl (level 0 sees the full result).
    function automatic int level_width(input int width, input int fanin, input int lvl);
        int w;
        w = width;
        for (int i = 0; i < lvl; i++) w = (w + fanin - 1) / fanin;
        return w;
    endfunction

    // ceil(log_fanin(width)), computed as repeated ceiling division down to one bit.
    function automatic int calc_levels(input int width, input int fanin);
        int w;
        int n;
        w = width;
        n = 0;
        while (w > 1) begin
            w = (w + fanin - 1) / fanin;
            n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/or_reduce_level.sv
// One OR-reduction level: groups of FANIN input bits collapse to one bit, short last group zero-padded.
module or_reduce_level
    import flag_pkg::*;
#(
    parameter int  IN_W  = DEF_WIDTH,
    parameter int  FANIN = DEF_FANIN,
    parameter bit  REG   = 1'b1,
    localparam int OUT_W = (IN_W + FANIN - 1) / FANIN
) (
    input  logic             clk,
    input  logic [IN_W-1:0]  d,
    output logic [OUT_W-1:0] q
);

    localparam int PAD_W = OUT_W * FANIN;

    logic [PAD_W-1:0] padded;
    logic [OUT_W-1:0] ored;

    assign padded = PAD_W'(d);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        ored = '0;
        for (int g = 0; g < OUT_W; g++) ored[g] = |padded[g*FANIN +: FANIN];
    end

    if (REG) begin : g_reg
        // NOTE: datapath registers carry no reset; the valid pipe in the parent qualifies them.
        always_ff @(posedge clk) q <= ored;
    end else begin : g_comb
        assign q = ored;
    end

endmodule

// File: rtl/flag_unit_pipe.sv
// Pipelined NZCV flag unit: registered OR-tree zero detect, matched sideband delay line, flag register.
// Define FLAG_BYPASS_EN to forward emerging flags combinationally onto nzcv.
module flag_unit_pipe
    import flag_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int FANIN      = DEF_FANIN,
    parameter int REG_LEVELS = DEF_REG_LEVELS
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] result,
    input  logic             carry_in,
    input  logic             ovf_in,
    input  logic             set_flags,
    input  logic             flush,
    output logic             out_valid,
    output logic             out_n,
    output logic             out_z,
    output logic             out_c,
    output logic             out_v,
    output logic [3:0]       nzcv,
    output logic             flags_written
);

    localparam int LEVELS = calc_levels(WIDTH, FANIN);
    localparam int LAT    = (REG_LEVELS != 0) ? LEVELS : 1;

    logic           tree_or;
    logic [LAT-1:0] vld_q;
    side_t          side_q [LAT];
    side_t          side_out;
    logic [3:0]     new_flags;
    logic [3:0]     nzcv_q;

    // With REG_LEVELS=0 only the last level registers, giving the single output register.
    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int IN_W  = level_width(WIDTH, FANIN, l);
        localparam int OUT_W = level_width(WIDTH, FANIN, l + 1);

        logic [IN_W-1:0]  d;
        logic [OUT_W-1:0] q;

        if (l == 0) begin : g_first
            assign d = result;
        end else begin : g_next
            assign d = g_lvl[l-1].q;
        end

        or_reduce_level #(
            .IN_W  (IN_W),
            .FANIN (FANIN),
            .REG   (bit'((REG_LEVELS != 0) || (l == LEVELS - 1)))
        ) u_level (
            .clk (clk),
            .d   (d),
            .q   (q)
        );
    end

    assign tree_or = g_lvl[LEVELS-1].q[0];

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= in_valid;
            for (int i = 1; i < LAT; i++) vld_q[i] <= vld_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        side_q[0] <= '{n: result[WIDTH-1], c: carry_in, v: ovf_in, set: set_flags};
        for (int i = 1; i < LAT; i++) side_q[i] <= side_q[i-1];
    end

    assign side_out      = side_q[LAT-1];
    assign out_valid     = vld_q[LAT-1];
    assign out_n         = out_valid & side_out.n;
    assign out_z         = out_valid & ~tree_or;
    assign out_c         = out_valid & side_out.c;
    assign out_v         = out_valid & side_out.v;
    assign flags_written = out_valid & side_out.set;

    always_comb begin
        new_flags        = '0;
        new_flags[N_BIT] = out_n;
        new_flags[Z_BIT] = out_z;
        new_flags[C_BIT] = out_c;
        new_flags[V_BIT] = out_v;
    end

    // A flush does not gate this write: the entry emerging in the flush cycle still lands.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            nzcv_q <= '0;
        end else if (flags_written) begin
            nzcv_q <= new_flags;
        end
    end

`ifdef FLAG_BYPASS_EN
    assign nzcv = flags_written ? new_flags : nzcv_q;
`else
    assign nzcv = nzcv_q;
`endif

endmodule

// File: tb/tb_flag_unit_pipe.sv
// Scoreboard bench for flag_unit_pipe (WIDTH=64, FANIN=4, REG_LEVELS=1): directed scenarios plus random traffic.
module tb_flag_unit_pipe;

    localparam int WIDTH = 64;
    localparam int LAT   = 3;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] result = '0;
    logic             carry_in = 1'b0;
    logic             ovf_in = 1'b0;
    logic             set_flags = 1'b0;
    logic             flush = 1'b0;
    logic             out_valid, out_n, out_z, out_c, out_v, flags_written;
    logic [3:0]       nzcv;

    typedef struct {
        int         due;
        logic [3:0] f;
        logic       s;
    } exp_t;

    exp_t       sb[$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    bit         mon_en = 1'b0;
    logic [3:0] exp_nzcv = 4'b0000;
    logic       mv, mw;
    logic [3:0] mf, mvis;

    flag_unit_pipe #(.WIDTH(WIDTH), .FANIN(4), .REG_LEVELS(1)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .result        (result),
        .carry_in      (carry_in),
        .ovf_in        (ovf_in),
        .set_flags     (set_flags),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_n         (out_n),
        .out_z         (out_z),
        .out_c         (out_c),
        .out_v         (out_v),
        .nzcv          (nzcv),
        .flags_written (flags_written)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Drive one cycle of stimulus; the reference model records what must emerge LAT cycles later.
    task automatic drive(input logic v, input logic [63:0] r, input logic c, input logic o,
                         input logic s, input logic f, input logic rn);
        in_valid  = v;
        result    = r;
        carry_in  = c;
        ovf_in    = o;
        set_flags = s;
        flush     = f;
        reset_n   = rn;
        if (rn && v && !f)
            sb.push_back('{due: cyc + LAT, f: {r[63], r == 64'd0, c, o}, s: s});
        if (!rn || f)
            while (sb.size() > 0 && sb[sb.size()-1].due > cyc) void'(sb.pop_back());
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mv = (sb.size() > 0) && (sb[0].due == cyc);
            check("out_valid", 64'(out_valid), 64'(mv));
            if (mv) begin
                mf = sb[0].f;
                mw = sb[0].s;
                check("out_flags", 64'({out_n, out_z, out_c, out_v}), 64'(mf));
                void'(sb.pop_front());
            end else begin
                mf = 4'b0000;
                mw = 1'b0;
            end
            check("flags_written", 64'(flags_written), 64'(mw));
`ifdef FLAG_BYPASS_EN
            mvis = mw ? mf : exp_nzcv;
`else
            mvis = exp_nzcv;
`endif
            check("nzcv", 64'(nzcv), 64'(mvis));
            if (!reset_n)  exp_nzcv = 4'b0000;
            else if (mw)   exp_nzcv = mf;
        end
    end

    initial begin
        logic [63:0] r;
        logic        kb;
        int          sel;

        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Reset held with in_valid asserted.
        drive(1'b1, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_nzcv", 64'(nzcv), 64'd0);
        check("reset_flags_written", 64'(flags_written), 64'd0);

        // Walking one after a zero result.
        drive(1'b1, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 64; i++) drive(1'b1, 64'd1 << i, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(4);
        check("walk_last_nzcv", 64'(nzcv), 64'(4'b1000));

        // set_flags=0 must leave NZCV alone.
        drive(1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(5);
        check("gate_nzcv", 64'(nzcv), 64'(4'b1000));

        // Streaming alternating zero / all-ones, carry on odd entries.
        for (int k = 0; k < 10; k++) begin
            kb = k[0];
            drive(1'b1, kb ? '1 : 64'd0, kb, 1'b0, 1'b1, 1'b0, 1'b1);
        end
        idle(5);
        check("stream_last_nzcv", 64'(nzcv), 64'(4'b1010));

        // Flush with a fourth entry in the same cycle: only the first entry survives.
        drive(1'b1, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        drive(1'b1, '1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b1, '1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(5);
        check("flush_nzcv", 64'(nzcv), 64'(4'b0101));

        // Reset with three entries in flight.
        drive(1'b1, '1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        drive(1'b1, '1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("midreset_out_valid", 64'(out_valid), 64'd0);
        check("midreset_nzcv", 64'(nzcv), 64'd0);
        idle(5);
        check("midreset_late_nzcv", 64'(nzcv), 64'd0);

        // Random traffic with occasional flushes and resets.
        for (int k = 0; k < 400; k++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0:       r = 64'd0;
                1:       r = 64'd1 << $urandom_range(0, 63);
                2:       r = '1;
                default: r = {$urandom, $urandom};
            endcase
            drive($urandom_range(0, 3) != 0, r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0, $urandom_range(0, 49) != 0);
        end
        idle(6);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/flag_unit_pipe.md
# flag_unit_pipe

Parametrised, pipelined ALU status-flag unit for the 64-bit datapath. Takes an ALU result plus adder carry/overflow, reduces the result to a zero flag through a registered OR-reduction tree, and updates an architectural NZCV flag register when the instruction requests flag setting. It sits between the ALU output and branch/condition logic, replacing the purely combinational zero-detect tree.

## Interface
Parameters:
- WIDTH, 64, result width in bits; must be 2 or greater.
- FANIN, 4, inputs per reduction node; must be 2 or greater.
- REG_LEVELS, 1, when 1 a register follows every reduction level; when 0 the tree is combinational with one output register.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  result, carry_in, ovf_in and set_flags are valid this cycle.
- result  in  WIDTH  ALU result.
- carry_in  in  1  adder carry-out.
- ovf_in  in  1  adder signed overflow.
- set_flags  in  1  the instruction writes NZCV.
- flush  in  1  kill all in-flight entries.
- out_valid  out  1  the out_* flags are valid.
- out_n, out_z, out_c, out_v  out  1 each  flags of the emerging result.
- nzcv  out  4  architectural flags; bit 3=N, 2=Z, 1=C, 0=V.
- flags_written  out  1  the NZCV register is updated this cycle.

## Operation
- LEVELS = ceil(log_FANIN(WIDTH)). Example: WIDTH=64, FANIN=4 gives LEVELS=3.
- Each level ORs groups of FANIN bits. A short final group is padded with 0.
- Z = NOT(final OR). N = result[WIDTH-1].
- N, C, V, set_flags and valid travel in a delay line matched to the tree latency.
- Flags are updated at the edge where out_valid && set_q is true:
  - N, Z, C and V load from out_n, out_z, out_c and out_v.
  - flags_written is high in the cycle before that edge, while out_valid && set_q holds.
- An emerging entry with set_q=0 leaves NZCV unchanged.
- flush clears every valid bit in the pipe at the next edge, including an in_valid accepted in the same cycle.
  - Data bits may keep stale values; they have no effect while valid is 0.
  - NZCV is not affected by flush. An entry emerging in the flush cycle still writes NZCV.
- There is no backpressure. One entry can be accepted per cycle, and in_valid may be high every cycle.
- Reset (reset_n=0 at an edge) clears all pipeline valid bits, out_* and nzcv to 0, and flags_written to 0. Reset overrides flush and in_valid. Entries in flight when reset is asserted are lost.

## Timing
- Latency from in_valid to out_valid: LEVELS cycles when REG_LEVELS=1, and 1 cycle when REG_LEVELS=0.
- Throughput: 1 result per cycle.
- nzcv shows the written value one cycle after out_valid && set_q, unless FLAG_BYPASS_EN is defined.
- Back-to-back flag-setting entries write in order. The last one wins each cycle.

## Configuration
- FLAG_BYPASS_EN
  - Defined: nzcv is combinational. In a cycle with out_valid && set_q it shows {out_n, out_z, out_c, out_v}; otherwise it shows the register. Consumers see new flags in the same cycle they emerge.
  - Undefined: nzcv is the register output only.

## Structure
- Package flag_pkg holds:
  - the NZCV bit-index constants N_BIT=3, Z_BIT=2, C_BIT=1, V_BIT=0;
  - a function computing LEVELS from WIDTH and FANIN;
  - the default parameter values.
- Sub-module or_reduce_level: one reduction level, with parameters IN_W and FANIN and an optional output register. flag_unit_pipe instantiates it LEVELS times in a generate loop.

## Test plan
All scenarios use WIDTH=64, FANIN=4, REG_LEVELS=1, so latency is 3.
- Reset: hold reset_n=0 for 2 cycles with in_valid=1 and result=0 → out_valid=0, nzcv=4'b0000, flags_written=0.
- Walking one: result=0, then 1<<i for i=0..63, each with set_flags=1 → 3 cycles later out_z=1 for the zero entry and out_z=0 for every 1<<i. N=1 only for i=63. nzcv follows with the correct lag.
- Set-flags gating: result=0 with set_flags=0, after nzcv=4'b1000 → out_z=1 but nzcv stays 4'b1000 and flags_written=0.
- Streaming: 10 consecutive entries alternating 0 and 64'hFFFF_FFFF_FFFF_FFFF, carry_in=1 on odd entries → out_valid high for 10 cycles starting at cycle 3. nzcv sequence is 0100, 1010, 0100, ... with a one-cycle lag (none with FLAG_BYPASS_EN).
- Flush: inject 3 entries, then pulse flush together with a 4th in_valid → no out_valid afterward except the entry emerging in the flush cycle, and nzcv reflects only that entry.
- Reset mid-stream: drop reset_n while 3 entries are in flight → out_valid=0 and nzcv=0 the next cycle, and no later writes from the lost entries.
